// File: rtl/id_ex_stage.sv
// RV32I decode stage: register-file addressing, operand capture, immediate/control decode and load-use stall into the ID/EX register.
// Define ID_WB_BYPASS_EN to forward the same-cycle write-back value onto the captured operands.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplus4_i,
  input  logic            valid_i,
  output logic [RA_W-1:0] a1_o,
  output logic [RA_W-1:0] a2_o,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_e_i,
  output logic            stall_d_o,
  output logic            valid_e_o,
  output logic [XLEN-1:0] pc_e_o,
  output logic [XLEN-1:0] pcplus4_e_o,
  output logic [XLEN-1:0] rd1_e_o,
  output logic [XLEN-1:0] rd2_e_o,
  output logic [XLEN-1:0] imm_e_o,
  output logic [RA_W-1:0] rs1_e_o,
  output logic [RA_W-1:0] rs2_e_o,
  output logic [RA_W-1:0] rd_e_o,
  output logic [6:0]      opcode_e_o,
  output logic [2:0]      funct3_e_o,
  output logic            funct7b5_e_o,
  output logic            regwrite_e_o,
  output logic            is_load_e_o,
  output logic            illegal_e_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regwrite;
    logic            is_load;
    logic            illegal;
  } ex_t;

  ex_t ex_d, ex_q;

  logic [6:0]        opcode;
  logic [RA_W-1:0]   rd;
  logic              legal, uses_rs1, uses_rs2, writes_rd, hazard;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   opnd1, opnd2;

  assign opcode = instr_i[6:0];
  assign rd     = RA_W'(instr_i[11:7]);
  assign a1_o   = RA_W'(instr_i[19:15]);
  assign a2_o   = RA_W'(instr_i[24:20]);

`ifndef ID_WB_BYPASS_EN
  logic wb_unused;
  assign wb_unused = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

  always_comb begin
    legal     = 1'b1;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    imm32     = '0;
    case (opcode)
      OP_REG: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD, OP_IMM, OP_JALR: begin
        writes_rd = 1'b1;
        imm32     = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        uses_rs2 = 1'b1;
        imm32    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        imm32    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        uses_rs1  = 1'b0;
        writes_rd = 1'b1;
        imm32     = {instr_i[31:12], 12'b0};
      end
      OP_JAL: begin
        uses_rs1  = 1'b0;
        writes_rd = 1'b1;
        imm32     = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OP_FENCE, OP_SYSTEM: begin
        writes_rd = 1'b0;
      end
      default: begin
        legal    = 1'b0;
        uses_rs1 = 1'b0;
      end
    endcase

    // Register file writes on the edge, so a same-cycle write-back is not yet visible on rdN_i.
    if (a1_o == '0)
      opnd1 = '0;
`ifdef ID_WB_BYPASS_EN
    else if (wb_we_i && wb_rd_i == a1_o)
      opnd1 = wb_data_i;
`endif
    else
      opnd1 = rd1_i;

    if (a2_o == '0)
      opnd2 = '0;
`ifdef ID_WB_BYPASS_EN
    else if (wb_we_i && wb_rd_i == a2_o)
      opnd2 = wb_data_i;
`endif
    else
      opnd2 = rd2_i;

    hazard    = (uses_rs1 && a1_o == ex_q.rd) || (uses_rs2 && a2_o == ex_q.rd);
    stall_d_o = ex_q.valid && ex_q.is_load && (ex_q.rd != '0) && valid_i && !flush_e_i && hazard;

    ex_d = '0;
    if (!flush_e_i && !stall_d_o) begin
      ex_d.valid    = valid_i;
      ex_d.pc       = pc_i;
      ex_d.pcplus4  = pcplus4_i;
      ex_d.rd1      = opnd1;
      ex_d.rd2      = opnd2;
      ex_d.imm      = XLEN'(imm32);
      ex_d.rs1      = a1_o;
      ex_d.rs2      = a2_o;
      ex_d.rd       = rd;
      ex_d.opcode   = opcode;
      ex_d.funct3   = instr_i[14:12];
      ex_d.funct7b5 = instr_i[30];
      ex_d.regwrite = valid_i && legal && writes_rd && (rd != '0);
      ex_d.is_load  = valid_i && (opcode == OP_LOAD);
      ex_d.illegal  = valid_i && !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign valid_e_o    = ex_q.valid;
  assign pc_e_o       = ex_q.pc;
  assign pcplus4_e_o  = ex_q.pcplus4;
  assign rd1_e_o      = ex_q.rd1;
  assign rd2_e_o      = ex_q.rd2;
  assign imm_e_o      = ex_q.imm;
  assign rs1_e_o      = ex_q.rs1;
  assign rs2_e_o      = ex_q.rs2;
  assign rd_e_o       = ex_q.rd;
  assign opcode_e_o   = ex_q.opcode;
  assign funct3_e_o   = ex_q.funct3;
  assign funct7b5_e_o = ex_q.funct7b5;
  assign regwrite_e_o = ex_q.regwrite;
  assign is_load_e_o  = ex_q.is_load;
  assign illegal_e_o  = ex_q.illegal;

endmodule
